// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a runtime-loadable
// PAT_W-bit pattern, overlapping/non-overlapping detection, a sample enable
// and a saturating match counter. The pattern MSB is the first bit received.
module seq_detect_param #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_RST     = 4'b1011,
  parameter bit               OVERLAP_RST = 1'b1,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         in_i,
  input  logic                         pat_load_i,
  input  logic [PAT_W-1:0]             pat_in_i,
  input  logic                         ovl_in_i,
  input  logic                         clr_cnt_i,
  output logic                         out_o,
  output logic [CNT_W-1:0]             match_cnt_o,
  output logic [$clog2(PAT_W+1)-1:0]   fill_o
);

  localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Architectural state
  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic              ovl_q,  ovl_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q,  out_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  // Candidate next values for a sampling edge
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              sample;
  logic              match;

  // Shifted history, saturating fill and the match decision on next-state values
  always_comb begin
    sample     = en_i & ~pat_load_i;
    hist_shift = {hist_q[PAT_W-2:0], in_i};
    fill_inc   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    match      = sample && (fill_inc == FILL_MAX) && (hist_shift == pat_q);
  end

  // Pattern/mode load, history shift, fill tracking and match pulse
  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = match;
    if (pat_load_i) begin
      // A load restarts detection; the bit presented at this edge is dropped.
      pat_d  = pat_in_i;
      ovl_d  = ovl_in_i;
      fill_d = '0;
    end else if (en_i) begin
      hist_d = hist_shift;
      // Non-overlapping mode demands PAT_W fresh bits after every match.
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  // Saturating match counter; a clear coinciding with a match keeps that match
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q  <= PAT_RST;
      ovl_q  <= OVERLAP_RST;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_o       = out_q;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed vector table, hand-written
// reset/counter sequences and a randomized run against a queue-based model.
module tb_seq_detect_param;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          in_b = 1'b0;
  logic          ld = 1'b0;
  logic [PW-1:0] pat = '0;
  logic          ovl = 1'b0;
  logic          clr = 1'b0;

  logic          out8, out2;
  logic [7:0]    cnt8;
  logic [1:0]    cnt2;
  logic [2:0]    fill8, fill2;

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP_RST(1'b1), .CNT_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(in_b), .pat_load_i(ld),
    .pat_in_i(pat), .ovl_in_i(ovl), .clr_cnt_i(clr),
    .out_o(out8), .match_cnt_o(cnt8), .fill_o(fill8)
  );

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP_RST(1'b1), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_i(in_b), .pat_load_i(ld),
    .pat_in_i(pat), .ovl_in_i(ovl), .clr_cnt_i(clr),
    .out_o(out2), .match_cnt_o(cnt2), .fill_o(fill2)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s step=%0d: got %0d expected %0d", nm, nstep, act, exp_v);
    end
  endtask

  task automatic check_all(input int x_out, input int x_c8, input int x_c2, input int x_fill);
    chk("out8", int'(out8), x_out);
    chk("out2", int'(out2), x_out);
    chk("cnt8", int'(cnt8), x_c8);
    chk("cnt2", int'(cnt2), x_c2);
    chk("fill8", int'(fill8), x_fill);
    chk("fill2", int'(fill2), x_fill);
  endtask

  // Apply one set of inputs across one rising edge, then check just after it.
  task automatic step(input bit e, input bit b, input bit l, input logic [PW-1:0] p,
                      input bit o, input bit c,
                      input int x_out, input int x_c8, input int x_c2, input int x_fill);
    en = e; in_b = b; ld = l; pat = p; ovl = o; clr = c;
    @(posedge clk);
    #1;
    nstep++;
    $display("step %0d en=%0b in=%0b ld=%0b pat=%b ovl=%0b clr=%0b -> out=%0b cnt8=%0d cnt2=%0d fill=%0d",
             nstep, e, b, l, p, o, c, out8, cnt8, cnt2, fill8);
    check_all(x_out, x_c8, x_c2, x_fill);
  endtask

  // Asynchronous reset asserted mid-cycle; checked before any clock edge.
  task automatic async_reset();
    #2;
    en = 1'b0; ld = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-cycle -> out=%0b cnt8=%0d fill=%0d", out8, cnt8, fill8);
    check_all(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    bit            en;
    bit            in;
    bit            ld;
    logic [PW-1:0] pat;
    bit            ovl;
    bit            clr;
    int            x_out;
    int            x_c8;
    int            x_c2;
    int            x_fill;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input bit e, input bit b, input bit l, input logic [PW-1:0] p,
                            input bit o, input bit c,
                            input int xo, input int x8, input int x2, input int xf);
    vec_t t;
    t.en = e; t.in = b; t.ld = l; t.pat = p; t.ovl = o; t.clr = c;
    t.x_out = xo; t.x_c8 = x8; t.x_c2 = x2; t.x_fill = xf;
    tbl.push_back(t);
  endfunction

  // ---------------- Reference model ----------------
  // The model keeps the bits seen since the last restart point and declares
  // a match whenever the newest PW of them spell the pattern.
  bit            mq[$];
  logic [PW-1:0] m_pat;
  bit            m_ovl;
  int            m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_pat = 4'b1011;
    m_ovl = 1'b1;
    m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit e, input bit b, input bit l,
                                     input logic [PW-1:0] p, input bit o, input bit c,
                                     output int xo, output int x8, output int x2, output int xf);
    bit m = 1'b0;
    if (l) begin
      m_pat = p;
      m_ovl = o;
      mq.delete();
    end else if (e) begin
      mq.push_back(b);
      if (mq.size() > PW) void'(mq.pop_front());
      if (mq.size() == PW) begin
        m = 1'b1;
        for (int i = 0; i < PW; i++)
          if (mq[i] != m_pat[PW-1-i]) m = 1'b0;
      end
      if (m && !m_ovl) mq.delete();
    end
    if (c) m_cnt = m ? 1 : 0;
    else if (m) m_cnt++;
    xo = m ? 1 : 0;
    x8 = (m_cnt > 255) ? 255 : m_cnt;
    x2 = (m_cnt > 3) ? 3 : m_cnt;
    xf = mq.size();
  endfunction

  initial begin
    int xo, x8, x2, xf;
    bit e, b, l, o, c;
    logic [PW-1:0] p;

    // Reset held: defaults visible without any edge dependency
    #12;
    $display("reset held -> out=%0b cnt8=%0d fill=%0d", out8, cnt8, fill8);
    check_all(0, 0, 0, 0);
    rst_n = 1'b1;

    // First match after reset, then overlapping continuation 0,1,1
    v(1,1,0,4'b0000,0,0, 0,0,0,1);
    v(1,0,0,4'b0000,0,0, 0,0,0,2);
    v(1,1,0,4'b0000,0,0, 0,0,0,3);
    v(1,1,0,4'b0000,0,0, 1,1,1,4);
    v(1,0,0,4'b0000,0,0, 0,1,1,4);
    v(1,1,0,4'b0000,0,0, 0,1,1,4);
    v(1,1,0,4'b0000,0,0, 1,2,2,4);
    v(0,0,0,4'b0000,0,0, 0,2,2,4);
    // Load non-overlapping 1011 with en=1 (load wins, bit discarded)
    v(1,1,1,4'b1011,0,0, 0,2,2,0);
    v(1,1,0,4'b0000,0,0, 0,2,2,1);
    v(1,0,0,4'b0000,0,0, 0,2,2,2);
    v(1,1,0,4'b0000,0,0, 0,2,2,3);
    v(1,1,0,4'b0000,0,0, 1,3,3,0);
    v(1,0,0,4'b0000,0,0, 0,3,3,1);
    v(1,1,0,4'b0000,0,0, 0,3,3,2);
    v(1,1,0,4'b0000,0,0, 0,3,3,3);
    // Counter clear alone
    v(0,0,0,4'b0000,0,1, 0,0,0,3);
    // Enable gaps between bits 2 and 3
    v(0,0,1,4'b1011,1,0, 0,0,0,0);
    v(1,1,0,4'b0000,0,0, 0,0,0,1);
    v(1,0,0,4'b0000,0,0, 0,0,0,2);
    v(0,1,0,4'b0000,0,0, 0,0,0,2);
    v(0,1,0,4'b0000,0,0, 0,0,0,2);
    v(0,1,0,4'b0000,0,0, 0,0,0,2);
    v(1,1,0,4'b0000,0,0, 0,0,0,3);
    v(1,1,0,4'b0000,0,0, 1,1,1,4);
    // Runtime pattern 0110, then two more bits without a match
    v(0,0,1,4'b0110,1,0, 0,1,1,0);
    v(1,0,0,4'b0000,0,0, 0,1,1,1);
    v(1,1,0,4'b0000,0,0, 0,1,1,2);
    v(1,1,0,4'b0000,0,0, 0,1,1,3);
    v(1,0,0,4'b0000,0,0, 1,2,2,4);
    v(1,1,0,4'b0000,0,0, 0,2,2,4);
    v(1,1,0,4'b0000,0,0, 0,2,2,4);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].en, tbl[i].in, tbl[i].ld, tbl[i].pat, tbl[i].ovl, tbl[i].clr,
           tbl[i].x_out, tbl[i].x_c8, tbl[i].x_c2, tbl[i].x_fill);

    // Mid-stream reset restores pattern 1011 and needs a full 4 samples again
    async_reset();
    step(1,1,0,4'b0000,0,0, 0,0,0,1);
    step(1,0,0,4'b0000,0,0, 0,0,0,2);
    step(1,1,0,4'b0000,0,0, 0,0,0,3);
    step(1,1,0,4'b0000,0,0, 1,1,1,4);
    // Counter saturation on the 2-bit instance
    step(1,0,0,4'b0000,0,0, 0,1,1,4);
    step(1,1,0,4'b0000,0,0, 0,1,1,4);
    step(1,1,0,4'b0000,0,0, 1,2,2,4);
    step(1,0,0,4'b0000,0,0, 0,2,2,4);
    step(1,1,0,4'b0000,0,0, 0,2,2,4);
    step(1,1,0,4'b0000,0,0, 1,3,3,4);
    step(1,0,0,4'b0000,0,0, 0,3,3,4);
    step(1,1,0,4'b0000,0,0, 0,3,3,4);
    step(1,1,0,4'b0000,0,0, 1,4,3,4);
    step(1,0,0,4'b0000,0,0, 0,4,3,4);
    step(1,1,0,4'b0000,0,0, 0,4,3,4);
    // Clear on a match edge keeps the match
    step(1,1,0,4'b0000,0,1, 1,1,1,4);

    // Randomized run against the model
    async_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        model_reset();
      end
      e = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1) == 1;
      l = ($urandom_range(0, 24) == 0);
      p = PW'($urandom_range(0, 15));
      o = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 29) == 0);
      model_edge(e, b, l, p, o, c, xo, x8, x2, xf);
      step(e, b, l, p, o, c, xo, x8, x2, xf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 1011 single-bit FSM detector. Compares a serial input stream against a runtime-loadable pattern of PAT_W bits and emits a one-cycle match pulse. Supports overlapping and non-overlapping detection, plus a sample-enable and a saturating match counter. Sits between a serial input source and downstream control or status logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PAT_RST, 4'b1011, pattern loaded at reset; MSB is the first bit received.
OVERLAP_RST, 1, detection mode at reset (1 = overlapping, 0 = non-overlapping).
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
en  input  1  sample-valid; `in` is consumed only on edges where en=1.
in  input  1  serial data bit.
pat_load  input  1  load pat_in and ovl_in at this edge.
pat_in  input  PAT_W  new pattern; MSB is the first bit received.
ovl_in  input  1  new overlap mode, taken with pat_load.
clr_cnt  input  1  synchronous clear of match_cnt.
out  output  1  registered match pulse, one cycle wide.
match_cnt  output  CNT_W  number of matches, saturating.
fill  output  clog2(PAT_W+1)  number of valid history bits (0..PAT_W).

Behaviour:
- Reset (rst=0, async): pattern register = PAT_RST; mode = OVERLAP_RST; history = 0; fill = 0; out = 0; match_cnt = 0.
- Sampling edge (en=1, pat_load=0):
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
- Match condition, evaluated on the next-state values: (fill_next == PAT_W) && (hist_next == pattern).
- out <= match at the same edge. Latency: the pulse is visible in the cycle after the edge that samples the final pattern bit. out is 0 on all other edges.
- Overlap mode = 1: fill stays saturated after a match, so a suffix of the match can start the next match.
- Overlap mode = 0: on a match, fill <= 0. History bits are retained, but a full PAT_W new bits are required before the next match.
- en=0: history, fill and match_cnt hold; out <= 0.
- pat_load=1 (takes priority over en):
  - pattern <= pat_in; mode <= ovl_in.
  - fill <= 0; out <= 0.
  - The in bit at that edge is discarded.
- match_cnt:
  - Increments by 1 on each match and saturates at all-ones (no wrap).
  - clr_cnt alone: match_cnt <= 0.
  - clr_cnt together with a match on the same edge: match_cnt <= 1 (the match is never lost).
- Reset asserted mid-stream: immediate clear of all state. The first post-reset match needs a full PAT_W samples.
- Fully synchronous datapath except rst. No combinational path from inputs to outputs.

Test Plan:
- Reset defaults: hold rst=0 → out=0, match_cnt=0, fill=0. Release rst and send en=1 with in=1,0,1,1 → out=1 in the cycle after the 4th edge only; match_cnt=1.
- Overlap: mode 1, stream 1,0,1,1,0,1,1 → out pulses after edges 4 and 7; match_cnt=2.
- Non-overlap: pat_load with pat_in=1011, ovl_in=0, then the same 7-bit stream → single pulse after edge 4; match_cnt=1; fill=3 after edge 7.
- Enable gaps: 1,0,1,1 with en=0 for 3 cycles between bits 2 and 3 → single pulse after the 4th enabled edge; no pulse during the gaps.
- Runtime pattern and mid-stream reset: pat_load with pat_in=0110 (PAT_W=4), stream 0,1,1,0 → match. Then assert rst=0 after 2 further bits → fill=0, pattern=1011, match_cnt=0.
- Counter edges (CNT_W=2): 4 matches → match_cnt saturates at 3. Then clr_cnt on a match edge → match_cnt=1.
